// File: rtl/bus_pkg.sv
// Shared definitions for the byte-lane bus: legal select patterns, the
// responder state encoding and the sel legality check.
package bus_pkg;

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Only aligned word, halfword and byte selects are legal.
  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel == SEL_WORD) || (sel == SEL_HI) || (sel == SEL_LO) ||
           (sel == SEL_B3)   || (sel == SEL_B2) || (sel == SEL_B1) ||
           (sel == SEL_B0);
  endfunction

endpackage

// File: rtl/bus_ram.sv
// DEPTH x 32 synchronous RAM, per-byte write enables, registered read port.
module bus_ram #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_wadr,
  input  logic [31:0]   i_wdat,
  input  logic [AW-1:0] i_radr,
  output logic [31:0]   o_rdat
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdat;

  // Byte-lane writes; lanes not enabled keep their old contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_wadr][b*8 +: 8] <= i_wdat[b*8 +: 8];
    end
  end

  // One-cycle read latency; a same-edge write is not bypassed.
  always_ff @(posedge clk_i) begin
    r_rdat <= r_mem[i_radr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/bus_responder.sv
// Classic-handshake bus slave: latches one request, classifies it, waits
// WAIT cycles, then terminates with a single-cycle ack or err. Writes are
// committed to the enabled byte lanes on the edge that ends the response.
module bus_responder
  import bus_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [3:0]    sel_i,
  input  logic [31:0]   dat_i,
  output logic [31:0]   dat_o,
  output logic          ack_o,
  output logic          err_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_adr;
  logic [3:0]    r_sel;
  logic          r_we;
  logic [31:0]   r_dat;
  logic          r_bad;
  logic          r_ack;
  logic          r_err;

  logic          w_req;
  logic          w_bad;
  logic [AW-1:0] w_radr;
  logic [3:0]    w_be;
  logic [31:0]   w_rdat;

  assign w_req = cyc_i & stb_i;
  assign w_bad = ~sel_legal(sel_i) | ({1'b0, adr_i} >= DEPTH_W);

  // Read port follows the live address in IDLE so data is ready one cycle
  // later even with no wait states; afterwards it re-reads the latched one.
  assign w_radr = (r_state == ST_IDLE) ? adr_i : r_adr;

  // Commit only a non-aborted, legal write, on the edge leaving RESP.
  assign w_be = (r_state == ST_RESP && cyc_i && r_we && !r_bad) ? r_sel : 4'b0000;

  bus_ram #(.AW(AW), .DEPTH(DEPTH)) u_ram (
    .clk_i  (clk_i),
    .i_be   (w_be),
    .i_wadr (r_adr),
    .i_wdat (r_dat),
    .i_radr (w_radr),
    .o_rdat (w_rdat)
  );

  // Transaction FSM with registered ack/err (asserted when entering RESP).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_bad   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr <= adr_i;
            r_sel <= sel_i;
            r_we  <= we_i;
            r_dat <= dat_i;
            r_bad <= w_bad;
            if (WAIT == 0) begin
              r_state <= ST_RESP;
              r_ack   <= ~w_bad;
              r_err   <= w_bad;
            end else begin
              r_state <= ST_WAITING;
              r_cnt   <= 4'(WAIT - 1);
            end
          end
        end
        ST_WAITING: begin
          if (!cyc_i) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_ack   <= ~r_bad;
            r_err   <= r_bad;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack_o = r_ack;
  assign err_o = r_err;
  assign dat_o = r_ack ? w_rdat : 32'h0;

endmodule
